// File: rtl/issueunit_int.sv
// +--------------------------------------------------------------------------+
// | issueunit_int: integer issue/execute unit with fixed-latency ALU and CDB  |
// | request/grant result hold.                        Revision: 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module issueunit_int #(
  parameter int EXEC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  issueint_opcode,
  input  logic [5:0]  issueint_rdtag,
  input  logic [31:0] issueint_rsdata,
  input  logic [31:0] issueint_rtdata,
  input  logic        issueint_ready,
  output logic        issueint_done,
  output logic        cdbint_req,
  output logic [5:0]  cdbint_tag,
  output logic [31:0] cdbint_data,
  input  logic        cdbint_grant,
  output logic        cdbint_valid,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;
  localparam logic [3:0] LAT_M1   = 4'(EXEC_LAT - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  op;
  logic [5:0]  rdtag_hold;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [5:0]  tag;
  logic [31:0] result;
  logic [31:0] alu_out;
  logic        take;

  // done is gated by reset so the queue never shifts while the unit is held in reset
  assign issueint_done = reset_n & ((state == S_IDLE) | ((state == S_RESULT) & cdbint_grant));
  assign take          = issueint_done & issueint_ready;
  assign cdbint_req    = reset_n & (state == S_RESULT);
  assign cdbint_valid  = cdbint_req & cdbint_grant;
  assign cdbint_tag    = tag;
  assign cdbint_data   = result;
  assign busy          = (state != S_IDLE);

  always_comb begin
    alu_out = rs_val + rt_val;
    case (op)
      3'd0: alu_out = rs_val + rt_val;
      3'd1: alu_out = rs_val - rt_val;
      3'd2: alu_out = rs_val & rt_val;
      3'd3: alu_out = rs_val | rt_val;
      3'd4: alu_out = rs_val ^ rt_val;
      3'd5: alu_out = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
      3'd6: alu_out = rt_val << rs_val[4:0];
      3'd7: alu_out = rt_val >> rs_val[4:0];
      default: alu_out = rs_val + rt_val;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      op         <= 3'd0;
      rdtag_hold <= 6'd0;
      rs_val     <= 32'd0;
      rt_val     <= 32'd0;
      tag        <= 6'd0;
      result     <= 32'd0;
    end else begin
      if (take) begin
        op         <= issueint_opcode;
        rdtag_hold <= issueint_rdtag;
        rs_val     <= issueint_rsdata;
        rt_val     <= issueint_rtdata;
      end
      case (state)
        S_IDLE: begin
          if (take) begin
            state <= S_EXEC;
            cnt   <= LAT_M1;
          end
        end
        S_EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            result <= alu_out;
            tag    <= rdtag_hold;
            state  <= S_RESULT;
          end
        end
        S_RESULT: begin
          // a grant frees the result slot; a simultaneous accept starts the next op
          if (cdbint_grant) begin
            if (take) begin
              state <= S_EXEC;
              cnt   <= LAT_M1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_issueunit_int.sv
// +--------------------------------------------------------------------------+
// | tb_issueunit_int: scoreboard bench for issueunit_int at EXEC_LAT 1 and 3. |
// |                                                   Revision: 1.0           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_issueunit_int;

  typedef struct {
    int          inst;
    logic [5:0]  tag;
    logic [31:0] data;
    int          acc;
    bit          seen;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [2:0]  opc  [2];
  logic [5:0]  rdt  [2];
  logic [31:0] rsd  [2];
  logic [31:0] rtd  [2];
  logic        rdy  [2];
  logic        dn   [2];
  logic        req  [2];
  logic [5:0]  ctag [2];
  logic [31:0] cdat [2];
  logic        gnt  [2];
  logic        vld  [2];
  logic        bsy  [2];

  int   gmode [2];
  logic gman  [2];
  logic rnd   [2];

  exp_t sb[$];
  int   vc1[$];
  int   cyc;
  int   n_vec;
  int   n_err;

  assign gnt[0] = (gmode[0] == 1) | ((gmode[0] == 2) & rnd[0]) | ((gmode[0] == 3) & gman[0]);
  assign gnt[1] = (gmode[1] == 1) | ((gmode[1] == 2) & rnd[1]) | ((gmode[1] == 3) & gman[1]);

  issueunit_int #(.EXEC_LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .issueint_opcode(opc[0]), .issueint_rdtag(rdt[0]),
    .issueint_rsdata(rsd[0]), .issueint_rtdata(rtd[0]),
    .issueint_ready(rdy[0]), .issueint_done(dn[0]),
    .cdbint_req(req[0]), .cdbint_tag(ctag[0]), .cdbint_data(cdat[0]),
    .cdbint_grant(gnt[0]), .cdbint_valid(vld[0]), .busy(bsy[0])
  );

  issueunit_int #(.EXEC_LAT(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .issueint_opcode(opc[1]), .issueint_rdtag(rdt[1]),
    .issueint_rsdata(rsd[1]), .issueint_rtdata(rtd[1]),
    .issueint_ready(rdy[1]), .issueint_done(dn[1]),
    .cdbint_req(req[1]), .cdbint_tag(ctag[1]), .cdbint_data(cdat[1]),
    .cdbint_grant(gnt[1]), .cdbint_valid(vld[1]), .busy(bsy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd[0] = 1'($urandom % 2);
    rnd[1] = 1'($urandom % 2);
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Reference ALU written straight from the opcode table
  function automatic logic [31:0] alu_ref(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(a % 32);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return b << sh;
      default: return b >> sh;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int head_of(input int k);
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].inst == k) return i;
    return -1;
  endfunction

  // Stimulus side: every accepted instruction pushes its expected result
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        if (rdy[k] && dn[k]) begin
          exp_t e;
          e.inst = k; e.tag = rdt[k]; e.data = alu_ref(opc[k], rsd[k], rtd[k]);
          e.acc = cyc; e.seen = 1'b0;
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: compares every request cycle against the oldest outstanding result
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 2; k++) begin
        int h;
        h = head_of(k);
        check("valid_eq_req_and_grant", 32'(vld[k]), 32'(req[k] & gnt[k]));
        if (req[k]) begin
          if (h < 0) begin
            check("req_without_pending", 32'(req[k]), 32'd0);
          end else begin
            if (!sb[h].seen) begin
              check("req_latency", 32'(cyc), 32'(sb[h].acc + lat_of(k) + 1));
              sb[h].seen = 1'b1;
            end
            check("cdb_tag", 32'(ctag[k]), 32'(sb[h].tag));
            check("cdb_data", cdat[k], sb[h].data);
            if (vld[k]) begin
              if (k == 1) vc1.push_back(cyc);
              sb.delete(h);
            end
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic issue(input int k, input logic [2:0] o, input logic [5:0] t,
                       input logic [31:0] a, input logic [31:0] b);
    int   n;
    logic d;
    n = 0; d = 1'b0;
    opc[k] = o; rdt[k] = t; rsd[k] = a; rtd[k] = b; rdy[k] = 1'b1;
    while (!d && n < 300) begin
      @(negedge clk);
      d = dn[k];
      @(posedge clk);
      #1;
      n++;
    end
    rdy[k] = 1'b0;
    if (!d) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((bsy[k] || head_of(k) >= 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 300) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_run(input int k);
    for (int i = 0; i < 30; i++) begin
      if ($urandom % 3 == 0) begin
        repeat ($urandom % 3) @(posedge clk);
        #1;
      end
      issue(k, 3'($urandom % 8), 6'($urandom % 64), $urandom, $urandom);
    end
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      opc[k] = '0; rdt[k] = '0; rsd[k] = '0; rtd[k] = '0; rdy[k] = 1'b0;
      gmode[k] = 0; gman[k] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_done", 32'(dn[k]), 32'd0);
      check("rst_req", 32'(req[k]), 32'd0);
      check("rst_busy", 32'(bsy[k]), 32'd0);
      check("rst_tag", 32'(ctag[k]), 32'd0);
      check("rst_data", cdat[k], 32'd0);
    end
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("idle_done", 32'(dn[k]), 32'd1);
      check("idle_req", 32'(req[k]), 32'd0);
      check("idle_busy", 32'(bsy[k]), 32'd0);
    end

    // ADD wraps to zero; explicit cycle-by-cycle view of a single op
    gmode[0] = 1;
    issue(0, 3'd0, 6'h0A, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    check("add_exec_req", 32'(req[0]), 32'd0);
    @(negedge clk);
    check("add_req", 32'(req[0]), 32'd1);
    check("add_valid", 32'(vld[0]), 32'd1);
    check("add_tag", 32'(ctag[0]), 32'h0A);
    check("add_data", cdat[0], 32'd0);
    @(negedge clk);
    check("add_valid_once", 32'(vld[0]), 32'd0);
    check("add_busy_after", 32'(bsy[0]), 32'd0);
    @(posedge clk);
    #1;

    issue(0, 3'd5, 6'h11, 32'h8000_0000, 32'd1);
    issue(0, 3'd7, 6'h12, 32'h0000_0021, 32'h8000_0000);
    issue(0, 3'd6, 6'h13, 32'hFFFF_FFE4, 32'h0000_0003);
    wait_idle(0);

    // Grant withheld for five request cycles while the next op waits
    gmode[0] = 3; gman[0] = 1'b0;
    issue(0, 3'd3, 6'h21, 32'h1234_0000, 32'h0000_5678);
    opc[0] = 3'd4; rdt[0] = 6'h22; rsd[0] = 32'hA5A5_A5A5; rtd[0] = 32'hFFFF_0000; rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      check("hold_done", 32'(dn[0]), 32'd0);
      check("hold_req", 32'(req[0]), 32'd1);
      check("hold_tag", 32'(ctag[0]), 32'h21);
      check("hold_data", cdat[0], 32'h1234_5678);
      @(posedge clk);
      #1;
    end
    gman[0] = 1'b1;
    @(negedge clk);
    check("grant_done", 32'(dn[0]), 32'd1);
    check("grant_valid", 32'(vld[0]), 32'd1);
    @(posedge clk);
    #1;
    gman[0] = 1'b0; rdy[0] = 1'b0;
    check("b2b_accept_busy", 32'(bsy[0]), 32'd1);
    gmode[0] = 1;
    wait_idle(0);

    // Back-to-back SUBs with a permanent grant at EXEC_LAT=3
    gmode[1] = 1;
    vc1.delete();
    for (int i = 0; i < 4; i++)
      issue(1, 3'd1, 6'(6'h30 + i), $urandom, $urandom);
    wait_idle(1);
    check("b2b_count", 32'(vc1.size()), 32'd4);
    for (int i = 1; i < vc1.size(); i++)
      check("b2b_spacing", 32'(vc1[i] - vc1[i-1]), 32'd4);

    gmode[0] = 2; gmode[1] = 2;
    fork
      rand_run(0);
      rand_run(1);
    join
    gmode[0] = 1; gmode[1] = 1;
    wait_idle(0);
    wait_idle(1);

    // Reset while a result waits for a grant
    gmode[1] = 0;
    issue(1, 3'd0, 6'h3F, 32'd7, 32'd8);
    begin
      int n;
      n = 0;
      while (!req[1] && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("rstres_reach_result", 32'(req[1]), 32'd1);
    end
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    check("async_req", 32'(req[1]), 32'd0);
    check("async_valid", 32'(vld[1]), 32'd0);
    check("async_done", 32'(dn[1]), 32'd0);
    check("async_busy", 32'(bsy[1]), 32'd0);
    check("async_tag", 32'(ctag[1]), 32'd0);
    check("async_data", cdat[1], 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    gmode[1] = 1;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(vld[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(1, 3'd2, 6'h05, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    wait_idle(1);
    check("final_busy", 32'(bsy[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
